// File: rtl/aexm_dcache_resp.sv
// aexm_dcache_resp: direct-mapped write-through data-cache responder with word-wide refill
module aexm_dcache_resp #(
  parameter int LINES_LOG2 = 5,
  parameter int WORDS_LOG2 = 2
) (
  input  logic        gclk,
  input  logic        grst,
  input  logic        dc_stb,
  input  logic        dc_we,
  input  logic [29:0] dc_adr,
  input  logic [3:0]  dc_sel,
  input  logic [31:0] aexm_dcache_datao,
  output logic [31:0] aexm_dcache_datai,
  output logic        dc_ack,
  output logic        dc_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_adr,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_wdat,
  input  logic [31:0] mem_rdat,
  input  logic        mem_ack
);
  localparam int TAGW = 30 - LINES_LOG2 - WORDS_LOG2;
  localparam logic [2:0] IDLE = 3'd0, LOOKUP = 3'd1, REFILL = 3'd2, WRITE = 3'd3, RESP = 3'd4;
  logic [2:0] state;
  logic [29:0] adrQ;
  logic weQ;
  logic [3:0] selQ;
  logic [31:0] datQ;
  logic [WORDS_LOG2-1:0] cnt;
  logic [2**LINES_LOG2-1:0] valid;
  logic [TAGW-1:0] tagMem [2**LINES_LOG2];
  logic [31:0] dataMem [2**(LINES_LOG2+WORDS_LOG2)];
  logic [WORDS_LOG2-1:0] offset;
  logic [LINES_LOG2-1:0] idx;
  logic [TAGW-1:0] tag;
  logic [LINES_LOG2+WORDS_LOG2-1:0] lineWord;
  logic hit, legal;
  assign offset = adrQ[WORDS_LOG2-1:0];
  assign idx = adrQ[WORDS_LOG2 +: LINES_LOG2];
  assign tag = adrQ[29 -: TAGW];
  assign lineWord = {idx, offset};
  assign hit = valid[idx] && tagMem[idx] == tag;
  assign legal = selQ inside {4'h8, 4'h4, 4'h2, 4'h1, 4'hC, 4'h3, 4'hF};
  assign dc_ack = state == RESP;
  assign dc_err = dc_ack && !legal;
  assign mem_req = state == REFILL || state == WRITE;
  assign mem_we = state == WRITE;
  assign mem_adr = state == REFILL ? {tag, idx, cnt} : state == WRITE ? adrQ : '0;
  assign mem_sel = state == REFILL ? 4'hF : state == WRITE ? selQ : '0;
  assign mem_wdat = state == WRITE ? datQ : '0;
  always_ff @(posedge gclk) begin
    if (grst) begin
      state <= IDLE;
      valid <= '0;
      cnt <= '0;
      aexm_dcache_datai <= '0;
    end else begin
      case (state)
        IDLE: if (dc_stb) begin
          adrQ <= dc_adr;
          weQ <= dc_we;
          selQ <= dc_sel;
          datQ <= aexm_dcache_datao;
          state <= LOOKUP;
        end
        LOOKUP: begin
          cnt <= '0;
          if (!legal) state <= RESP;
          else if (weQ) begin
            state <= WRITE;
            // write-through: a hit updates the line, a miss leaves the cache untouched
            if (hit) for (int i = 0; i < 4; i++) if (selQ[i]) dataMem[lineWord][8*i +: 8] <= datQ[8*i +: 8];
          end else if (hit) begin
            aexm_dcache_datai <= dataMem[lineWord];
            state <= RESP;
          end else state <= REFILL;
        end
        REFILL: if (mem_ack) begin
          dataMem[{idx, cnt}] <= mem_rdat;
          if (cnt == offset) aexm_dcache_datai <= mem_rdat;
          cnt <= cnt + 1'b1;
          if (&cnt) begin
            valid[idx] <= 1'b1;
            tagMem[idx] <= tag;
            state <= RESP;
          end
        end
        WRITE: if (mem_ack) state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/aexm_dcache_resp.md
Name: aexm_dcache_resp

Overview:
- Data-side responder at the far end of the CPU data-cache interface.
- Accepts load/store requests from the core, with a byte-lane select and lane-replicated store data.
- Serves loads from a direct-mapped, write-through line store and refills misses from a word-wide backing-memory port.
- Returns full 32-bit words; the core's load sizer extracts the bytes.

Parameters:
- LINES_LOG2, 5: log2 number of cache lines.
- WORDS_LOG2, 2: log2 words per line; refill burst is 2^WORDS_LOG2 words.

Ports:
- gclk  in  1  system clock; all state updates on posedge.
- grst  in  1  synchronous active-high reset.
- dc_stb  in  1  request strobe; held high until dc_ack.
- dc_we  in  1  1 = store, 0 = load.
- dc_adr  in  30  word address [31:2].
- dc_sel  in  4  byte-lane select; legal codes are 8,4,2,1,C,3,F.
- aexm_dcache_datao  in  32  store data, already lane-replicated by the core.
- aexm_dcache_datai  out  32  load data, whole word.
- dc_ack  out  1  one-cycle completion pulse.
- dc_err  out  1  one-cycle pulse with dc_ack on an illegal dc_sel.
- mem_req  out  1  backing-memory request; held until mem_ack.
- mem_we  out  1  backing-memory write.
- mem_adr  out  30  backing-memory word address.
- mem_sel  out  4  backing-memory byte lanes.
- mem_wdat  out  32  backing-memory write data.
- mem_rdat  in  32  backing-memory read data; valid with mem_ack.
- mem_ack  in  1  backing-memory completion, one cycle per word.

Behaviour:
- Address split, LSB first: word offset WORDS_LOG2 bits, index LINES_LOG2 bits, remaining bits are the tag.
- Valid bits live in flops. Tag and data arrays may be RAM.
- Reset:
  - All valid bits cleared in the reset cycle.
  - FSM goes to IDLE.
  - dc_ack, dc_err, mem_req, mem_we = 0; aexm_dcache_datai = 0; mem_adr, mem_sel, mem_wdat = 0.
  - grst mid-refill or mid-write aborts the operation: mem_req is low the cycle after reset, the line stays invalid, and no dc_ack is issued.
- FSM states: IDLE, LOOKUP, REFILL, WRITE, RESP.
- IDLE:
  - When dc_stb=1, latch adr/we/sel/datao and go to LOOKUP.
  - Core inputs are ignored outside IDLE.
  - dc_stb must be low in the cycle after dc_ack; otherwise the request is re-accepted as a new one.
- LOOKUP: compare tag and valid.
  - Illegal sel: go to RESP with dc_err=1. No array or memory activity.
  - Load hit: go to RESP. datai = stored word.
  - Load miss: go to REFILL with word counter = 0.
  - Store: go to WRITE. On a hit, update only the lanes set in sel in the same cycle. A store miss does not allocate.
- REFILL:
  - mem_req=1, mem_we=0, mem_sel=F, mem_adr = {tag, index, counter}.
  - On each mem_ack: write mem_rdat to the line at that counter; capture it as the response word if the counter equals the requested offset; increment the counter.
  - mem_req may stay high across consecutive words.
  - On the last word's ack: set valid and tag, then go to RESP.
- WRITE:
  - mem_req=1, mem_we=1, mem_adr = latched adr, mem_sel = sel, mem_wdat = latched datao.
  - On mem_ack go to RESP.
- RESP: dc_ack=1 for exactly one cycle, datai stable, then IDLE.
- Latency, stb high to dc_ack:
  - Load hit: 3 cycles.
  - Load miss: 3 cycles + the sum of the refill ack waits.
  - Store: 3 cycles + the write ack wait.
- Holding: aexm_dcache_datai holds its value until the next load response. It does not change on a store ack.
- Same-line store after a refill hits and updates both the array and memory, so there are no stale reads.
- mem_ack outside REFILL or WRITE is ignored.
- Counter wrap: the last word is detected at counter = 2^WORDS_LOG2 - 1 and is not allowed to wrap into a fifth transfer.

Test Plan:
- Reset then load at adr 0x10 (index 4, word 0) with sel F:
  - REFILL issues exactly 4 reads at adr 0x10..0x13, returning 0xA0..0xA3.
  - dc_ack with datai = 0xA0.
  - dc_err stays 0 throughout.
- Repeat the same load:
  - dc_ack 3 cycles after stb.
  - datai = 0xA0.
  - mem_req stays 0.
- Store 0x5555_5555, sel 3, to adr 0x10, then load it:
  - mem write with sel 3 and wdat 0x5555_5555.
  - Subsequent load returns 0x0000_5555 with no memory traffic.
- Store miss to adr 0x200:
  - One mem write occurs.
  - A following load of 0x200 misses and refills (no allocate confirmed).
- dc_sel = 5:
  - dc_ack and dc_err together on the 3rd cycle.
  - No mem_req.
  - Arrays unchanged.
- grst asserted after the 2nd refill ack:
  - mem_req drops the next cycle; no dc_ack.
  - Reloading the same address performs a full 4-word refill.
